// File: rtl/hazard_control_if.sv
// rtl/hazard_control_if.sv - ID-stage hazard/forwarding signal bundle
interface hazard_control_if #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int STALL_COUNT_WIDTH = 16
);
    logic                         id_valid;
    logic [REG_ADDR_WIDTH-1:0]    id_rs;
    logic [REG_ADDR_WIDTH-1:0]    id_rt;
    logic                         id_usesRs;
    logic                         id_usesRt;
    logic                         id_shouldWriteRegister;
    logic [REG_ADDR_WIDTH-1:0]    id_destRegister;
    logic                         id_isLoad;
    logic                         ex_redirect;
    logic                         pipelineFreeze;
    logic                         id_shouldStall;
    logic                         idEx_insertBubble;
    logic                         ifId_flush;
    logic [1:0]                   id_forwardRs;
    logic [1:0]                   id_forwardRt;
    logic [STALL_COUNT_WIDTH-1:0] stallCount;

    modport master (
        output id_valid, id_rs, id_rt, id_usesRs, id_usesRt,
               id_shouldWriteRegister, id_destRegister, id_isLoad,
               ex_redirect, pipelineFreeze,
        input  id_shouldStall, idEx_insertBubble, ifId_flush,
               id_forwardRs, id_forwardRt, stallCount
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_usesRs, id_usesRt,
               id_shouldWriteRegister, id_destRegister, id_isLoad,
               ex_redirect, pipelineFreeze,
        output id_shouldStall, idEx_insertBubble, ifId_flush,
               id_forwardRs, id_forwardRt, stallCount
    );
endinterface

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - load-use stall, redirect kill and forwarding select for the ID stage
module hazard_control #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    hazard_control_if.slave hz
);
    typedef struct packed {
        logic                      valid;
        logic                      writes;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      is_load;
    } entry_t;

    entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic live_rs, live_rt, load_use;
    logic [1:0] sel_rs, sel_rt;

    function automatic logic producer_match(entry_t e, logic [REG_ADDR_WIDTH-1:0] src);
        return e.valid && e.writes && (e.dest != '0) && (e.dest == src);
    endfunction

    // WB hits fall back to the register file because it writes through.
    function automatic logic [1:0] fwd_sel(entry_t ex, entry_t mem, entry_t wb,
                                           logic live, logic [REG_ADDR_WIDTH-1:0] src);
        if (!live)                                        return 2'd0;
        else if (producer_match(ex, src) && !ex.is_load)  return 2'd1;
        else if (producer_match(mem, src))                return 2'd2;
        else if (producer_match(wb, src))                 return 2'd0;
        else                                              return 2'd0;
    endfunction

    assign live_rs  = hz.id_valid && hz.id_usesRs && (hz.id_rs != '0);
    assign live_rt  = hz.id_valid && hz.id_usesRt && (hz.id_rt != '0);
    assign load_use = ex_q.is_load &&
                      ((live_rs && producer_match(ex_q, hz.id_rs)) ||
                       (live_rt && producer_match(ex_q, hz.id_rt)));
    assign sel_rs   = fwd_sel(ex_q, mem_q, wb_q, live_rs, hz.id_rs);
    assign sel_rt   = fwd_sel(ex_q, mem_q, wb_q, live_rt, hz.id_rt);

    always_comb begin
        ex_d                 = ex_q;
        mem_d                = mem_q;
        wb_d                 = wb_q;
        stall_count_d        = stall_count_q;
        hz.id_shouldStall    = 1'b0;
        hz.idEx_insertBubble = 1'b0;
        hz.ifId_flush        = 1'b0;
        hz.id_forwardRs      = 2'd0;
        hz.id_forwardRt      = 2'd0;

        if (!reset) begin
            hz.id_shouldStall = 1'b0;
        end else if (hz.pipelineFreeze) begin
            hz.id_shouldStall = 1'b1;
            hz.id_forwardRs   = sel_rs;
            hz.id_forwardRt   = sel_rt;
        end else if (hz.ex_redirect) begin
            hz.ifId_flush        = 1'b1;
            hz.idEx_insertBubble = 1'b1;
        end else if (load_use) begin
            hz.id_shouldStall    = 1'b1;
            hz.idEx_insertBubble = 1'b1;
            if (!(&stall_count_q))
                stall_count_d = stall_count_q + 1'b1;
        end else begin
            hz.id_forwardRs = sel_rs;
            hz.id_forwardRt = sel_rt;
        end

        if (!hz.pipelineFreeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (hz.ex_redirect || load_use)
                ex_d = '0;
            else
                ex_d = '{valid:   hz.id_valid,
                         writes:  hz.id_shouldWriteRegister,
                         dest:    hz.id_destRegister,
                         is_load: hz.id_isLoad};
        end
    end

    assign hz.stallCount = stall_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline, sitting beside the ID stage.
- Produces the stall, bubble and forwarding controls that the ID/EX register captures.
- Keeps its own shadow of the destinations in flight in EX, MEM and WB, so it needs nothing from downstream except redirect and freeze.
- Also counts stall cycles for performance reporting.

Parameters:
- REG_ADDR_WIDTH, 5: register index width.
- STALL_COUNT_WIDTH, 16: width of the saturating stall counter.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_WIDTH each  source register indices.
- id_usesRs, id_usesRt  in  1 each  the ID instruction reads that source.
- id_shouldWriteRegister  in  1  the ID instruction writes the register file.
- id_destRegister  in  REG_ADDR_WIDTH  final destination index (Rt/Rd/31 already resolved).
- id_isLoad  in  1  the ID instruction is a load (result available only after MEM).
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- pipelineFreeze  in  1  external freeze (memory wait); whole pipeline holds.
- id_shouldStall  out  1  hold PC and IF/ID this cycle.
- idEx_insertBubble  out  1  ID/EX must load a NOP (all control bits 0).
- ifId_flush  out  1  IF/ID must load a NOP.
- id_forwardRs, id_forwardRt  out  2 each  0 = register file, 1 = from EX/MEM ALU result, 2 = from MEM/WB write data; captured into ID/EX and used in EX next cycle.
- stallCount  out  STALL_COUNT_WIDTH  saturating count of load-use stall cycles.

Behaviour:
- Shadow pipeline has three entries, EX, MEM and WB. Each entry holds {valid, writes, dest, isLoad}.
- On reset low: all entries invalid, stallCount = 0, all outputs 0. Outputs are combinational from the shadow entries and ID inputs, so they are 0 throughout reset.
- A source is "live" when id_valid=1, its uses bit is 1 and its index is not 0.
- An entry is a "producer" when valid=1, writes=1 and dest is not 0.
- Register 0 never stalls and never forwards.
- Load-use rule: loadUse = the EX entry is a producer with isLoad=1 and its dest equals a live source.
- Forward select rules for each source:
  - EX entry is a producer with matching dest and isLoad=0 -> select 1.
  - Otherwise, MEM entry is a producer with matching dest -> select 2.
  - Otherwise -> select 0.
  - The EX match takes priority over the MEM match (newest value wins).
  - A match in the WB entry gives select 0; the register file is write-through.
- Output priority, evaluated each cycle:
  1. pipelineFreeze=1: id_shouldStall=1, bubble=0, flush=0, shadow holds, counter holds.
  2. ex_redirect=1: ifId_flush=1, idEx_insertBubble=1, id_shouldStall=0. The ID instruction is killed and not stalled even if loadUse is set. Forward selects are 0.
  3. loadUse=1: id_shouldStall=1, idEx_insertBubble=1, forward selects 0, stallCount increments and saturates at all-ones.
  4. Otherwise: all controls 0 and forward selects as computed.
- Shadow advance on a rising edge when pipelineFreeze=0:
  - WB <= MEM, MEM <= EX.
  - EX <= {id_valid, id_shouldWriteRegister, id_destRegister, id_isLoad}, except EX <= invalid when bubble or redirect.
- Latency:
  - A load in EX causes exactly one stall cycle for a dependent ID instruction.
  - On the next cycle the load sits in MEM and the dependent gets select 2.
- Reset asserted mid-operation clears everything immediately. The first cycle after release behaves as an empty pipeline.

Test Plan:
- Back-to-back ALU dependency: add $3 writes in cycle N, sub reads $3 in cycle N+1 -> id_forwardRs=1, no stall.
- Distance-2 dependency: add $3 then nop then or reading $3 in rt -> id_forwardRt=2. Add a distance-3 case -> select 0.
- Load-use: lw $5 followed by add $6,$5,$5 -> one cycle with id_shouldStall=1 and idEx_insertBubble=1, stallCount 0->1; next cycle both forward selects = 2 and stall=0.
- Register 0: lw $0 followed by a use of $0 -> no stall, selects 0.
- Redirect during load-use: ex_redirect=1 in the same cycle as loadUse -> ifId_flush=1, bubble=1, stall=0, stallCount unchanged. Hold pipelineFreeze=1 for 3 cycles -> shadow and counter frozen, stall=1 throughout.
- Counter and reset: with STALL_COUNT_WIDTH=2, force 5 load-use stalls -> stallCount saturates at 3. Pulse reset low mid-stall -> all outputs 0 immediately, counter 0.
